seq_bit_serializer: RTL and testbench

SEQ_BIT_SERIALIZER -- requirements
Module: seq_bit_serializer

---
 rtl/seq_bit_serializer_pkg.sv | 14 +
 rtl/seq_ser_bit_cnt.sv | 31 +++
 rtl/seq_bit_serializer.sv | 115 +++++++++++
 tb/tb_seq_bit_serializer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/seq_bit_serializer_pkg.sv
// Shared types and defaults for the bit serializer.
// Holds the FSM state encoding and the default word width and idle level.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int   DEFAULT_WIDTH      = 8;
  localparam logic DEFAULT_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/seq_ser_bit_cnt.sv
// Loadable down-counter for the serializer.
// The count saturates at zero, and tc flags the final bit of a word.
module seq_ser_bit_cnt
  import seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic tc
);

  logic [CW-1:0] count;

  // The count starts at WIDTH-1 so that zero marks the last bit; it holds at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(WIDTH - 1);
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial converter feeding a downstream sequence detector.
// Define SEQ_SER_PARITY_EN to append an even-parity bit to every frame.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             in_bit,
  output logic             bit_valid,
  output logic             done
);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] shift_reg;
  logic             accept;
  logic             last_bit;
  logic             cur_bit;
  logic             data_bit;
  logic             shifting;

  assign accept   = load && ready;
  assign shifting = (state == SHIFT);
  assign cur_bit  = (MSB_FIRST != 0) ? shift_reg[WIDTH-1] : shift_reg[0];

  seq_ser_bit_cnt #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .load(accept),
    .dec (shifting),
    .tc  (last_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The word is captured at accept so later changes on data_in cannot disturb the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
    end else if (accept) begin
      shift_reg <= data_in;
    end else if (shifting) begin
      shift_reg <= (MSB_FIRST != 0) ? {shift_reg[WIDTH-2:0], 1'b0}
                                    : {1'b0, shift_reg[WIDTH-1:1]};
    end
  end

`ifdef SEQ_SER_PARITY_EN
  logic parity_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_bit <= 1'b0;
    end else if (accept) begin
      parity_bit <= ^data_in;
    end
  end
`endif

  // ready and done sit on the final cycle of a frame, so a load there chains frames without a gap.
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    done       = 1'b0;
    bit_valid  = 1'b0;
    data_bit   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (load) next_state = SHIFT;
      end
      SHIFT: begin
        bit_valid = 1'b1;
        data_bit  = cur_bit;
`ifdef SEQ_SER_PARITY_EN
        if (last_bit) next_state = PARITY;
`else
        if (last_bit) begin
          ready      = 1'b1;
          done       = 1'b1;
          next_state = load ? SHIFT : IDLE;
        end
`endif
      end
`ifdef SEQ_SER_PARITY_EN
      PARITY: begin
        bit_valid  = 1'b1;
        data_bit   = parity_bit;
        ready      = 1'b1;
        done       = 1'b1;
        next_state = load ? SHIFT : IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  assign in_bit = bit_valid ? data_bit : IDLE_LEVEL;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench for seq_bit_serializer: an MSB-first lane (idle 0) and an LSB-first lane (idle 1) share stimulus.
// Expected bit streams are hand-written per vector; honours SEQ_SER_PARITY_EN when defined.
module tb_seq_bit_serializer;

  localparam logic IDLE_MSB = 1'b0;
  localparam logic IDLE_LSB = 1'b1;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] data_in;

  logic m_ready, m_bit, m_valid, m_done;
  logic l_ready, l_bit, l_valid, l_done;

  int checks = 0;
  int fails  = 0;
  bit mon_en = 1'b0;

  // Each entry is {expected in_bit, expected done}
  logic [1:0] q_msb[$];
  logic [1:0] q_lsb[$];

  always #5 clk = ~clk;

  seq_bit_serializer #(
    .WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(IDLE_MSB)
  ) u_msb (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load),
    .ready(m_ready), .in_bit(m_bit), .bit_valid(m_valid), .done(m_done)
  );

  seq_bit_serializer #(
    .WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(IDLE_LSB)
  ) u_lsb (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load),
    .ready(l_ready), .in_bit(l_bit), .bit_valid(l_valid), .done(l_done)
  );

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Pushes a frame; stream is written in transmission order, leftmost bit first.
  task automatic pushFrame(input int lane, input logic [7:0] stream, input logic par);
    logic [1:0] item;
    for (int i = 7; i >= 0; i--) begin
`ifdef SEQ_SER_PARITY_EN
      item = {stream[i], 1'b0};
`else
      item = {stream[i], (i == 0)};
`endif
      if (lane == 0) q_msb.push_back(item);
      else           q_lsb.push_back(item);
    end
`ifdef SEQ_SER_PARITY_EN
    item = {par, 1'b1};
    if (lane == 0) q_msb.push_back(item);
    else           q_lsb.push_back(item);
`else
    item = {par, 1'b0};
`endif
  endtask

  task automatic monitorLane(input int lane, input logic v, input logic b,
                             input logic d, input logic r);
    int         sz;
    logic [1:0] item;
    logic       idl;
    sz  = (lane == 0) ? q_msb.size() : q_lsb.size();
    idl = (lane == 0) ? IDLE_MSB : IDLE_LSB;
    checkOutput($sformatf("lane%0d ready", lane), r, (sz <= 1));
    checkOutput($sformatf("lane%0d bit_valid", lane), v, (sz != 0));
    if (v === 1'b1 && sz != 0) begin
      item = (lane == 0) ? q_msb.pop_front() : q_lsb.pop_front();
      checkOutput($sformatf("lane%0d in_bit", lane), b, item[1]);
      checkOutput($sformatf("lane%0d done", lane), d, item[0]);
    end else if (v !== 1'b1) begin
      checkOutput($sformatf("lane%0d idle in_bit", lane), b, idl);
      checkOutput($sformatf("lane%0d idle done", lane), d, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      monitorLane(0, m_valid, m_bit, m_done, m_ready);
      monitorLane(1, l_valid, l_bit, l_done, l_ready);
    end
  end

  // One clock cycle of stimulus; the scoreboard is updated just after the monitor has sampled.
  task automatic applyStimulus(input logic r, input logic ld, input logic [7:0] d,
                               input logic [7:0] sm, input logic [7:0] sl,
                               input logic par, output bit accepted);
    @(posedge clk);
    #1;
    rst     = r;
    load    = ld;
    data_in = d;
    @(negedge clk);
    #1;
    accepted = 1'b0;
    if (r) begin
      q_msb.delete();
      q_lsb.delete();
    end else if (ld && q_msb.size() == 0) begin
      pushFrame(0, sm, par);
      pushFrame(1, sl, par);
      accepted = 1'b1;
    end
  endtask

  task automatic idleCycles(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, acc);
  endtask

  task automatic loadWord(input logic [7:0] d, input logic [7:0] sm,
                          input logic [7:0] sl, input logic par);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) applyStimulus(1'b0, 1'b1, d, sm, sl, par, acc);
    checkOutput($sformatf("load %h accepted within bound", d), acc, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;
    rst     = 1'b1;
    load    = 1'b0;
    data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, acc);

    $display("[TB] basic frame 8'hA5");
    loadWord(8'hA5, 8'b10100101, 8'b10100101, 1'b0);
    idleCycles(10);

    $display("[TB] back-to-back 8'h06 then 8'hB0");
    loadWord(8'h06, 8'b00000110, 8'b01100000, 1'b0);
    loadWord(8'hB0, 8'b10110000, 8'b00001101, 1'b1);
    idleCycles(10);

    $display("[TB] busy load of 8'hFF during 8'h00 frame");
    loadWord(8'h00, 8'b00000000, 8'b00000000, 1'b0);
    idleCycles(2);
    applyStimulus(1'b0, 1'b1, 8'hFF, 8'b11111111, 8'b11111111, 1'b0, acc);
    idleCycles(10);

    $display("[TB] mid-frame reset with simultaneous load");
    loadWord(8'hA5, 8'b10100101, 8'b10100101, 1'b0);
    idleCycles(3);
    applyStimulus(1'b1, 1'b1, 8'h3C, 8'b00111100, 8'b00111100, 1'b0, acc);
    idleCycles(1);
    loadWord(8'h3C, 8'b00111100, 8'b00111100, 1'b0);
    idleCycles(10);

    $display("[TB] single set bit 8'h01 and parity word 8'h07");
    loadWord(8'h01, 8'b00000001, 8'b10000000, 1'b1);
    idleCycles(10);
    loadWord(8'h07, 8'b00000111, 8'b11100000, 1'b1);
    idleCycles(10);

    for (int i = 0; i < 30 && (q_msb.size() != 0 || q_lsb.size() != 0); i++) idleCycles(1);
    checkOutput("scoreboard drained", (q_msb.size() == 0 && q_lsb.size() == 0), 1'b1);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
